vec_issue_seq: RTL

- Multi-word vector issue sequencer; the initiator side of the packed-int8 vector ALU interface (operands v1/v2, 3-bit ctrl, 32-bit result, 4-bit lane flags).
- Accepts one vector request (op, two source bases, destination base, length) and reads operand words from a 2-read-port register file.
- Drives each word pair into the vector ALU and writes the results back: element-wise for add/sub/pass, reduced into a single 32-bit sum for dot product.

---
 rtl/vec_issue_seq_if.sv | 17 +
 rtl/vec_issue_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vec_issue_seq_if.sv
// Request channel of the vector issue sequencer: one vector op, two source bases, a destination base and a length.
// valid/ready: a request transfers on a rising clock edge where valid and ready are both high; the initiator holds the fields stable while valid is high.
interface vec_issue_seq_if #(
    parameter int LEN_W = 4,
    parameter int AW    = 5
);
    logic             valid;
    logic             ready;
    logic [2:0]       op;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;

    modport master (output valid, op, len, rs1, rs2, rd, input ready);
    modport slave  (input valid, op, len, rs1, rs2, rd, output ready);
endinterface

// File: rtl/vec_issue_seq.sv
// Multi-word vector issue sequencer feeding a packed-int8 vector ALU, with element-wise or dot-product write-back.
// Optional macro VSEQ_PERF_EN adds completed-request and issued-word counters.
module vec_issue_seq #(
    parameter int LEN_W = 4,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vec_issue_seq_if.slave req,
    output logic [AW-1:0] rd_addr1_o,
    output logic [AW-1:0] rd_addr2_o,
    input  logic [31:0]   rd_data1_i,
    input  logic [31:0]   rd_data2_i,
    output logic [31:0]   valu_v1_o,
    output logic [31:0]   valu_v2_o,
    output logic [2:0]    valu_ctrl_o,
    input  logic [31:0]   valu_res_i,
    input  logic [3:0]    valu_over_i,
    output logic          wb_valid_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [31:0]   wb_data_o,
    output logic [3:0]    wb_over_o,
    output logic          done_o
`ifdef VSEQ_PERF_EN
    ,
    output logic [15:0]   ops_cnt_o,
    output logic [15:0]   words_cnt_o
`endif
);

    localparam logic [2:0] OP_VDP = 3'b001;

    typedef enum logic [1:0] {IDLE, ISSUE, REDUCE_WB, DONE} state_t;

    state_t           state;
    logic             ready_q;
    logic [2:0]       op_q;
    logic [LEN_W-1:0] len_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [AW-1:0]    rd_q;
    logic [LEN_W-1:0] k;
    logic [31:0]      acc;
    logic [3:0]       sticky;
    logic             wb_valid_q;
    logic [AW-1:0]    wb_addr_q;
    logic [31:0]      wb_data_q;
    logic [3:0]       wb_over_q;
    logic             done_q;

    logic             is_vdp;
    logic             last;
    logic [31:0]      acc_next;
    logic [3:0]       sticky_next;

    assign is_vdp      = (op_q == OP_VDP);
    assign last        = (k == len_q - LEN_W'(1));
    assign acc_next    = acc + valu_res_i;
    assign sticky_next = sticky | valu_over_i;

    // The register file reads combinationally, so addresses come straight from the latched bases.
    assign rd_addr1_o  = rs1_q + AW'(k);
    assign rd_addr2_o  = rs2_q + AW'(k);
    assign valu_v1_o   = rd_data1_i;
    assign valu_v2_o   = rd_data2_i;
    assign valu_ctrl_o = op_q;

    assign req.ready   = ready_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_over_o   = wb_over_q;
    assign done_o      = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            op_q       <= '0;
            len_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            k          <= '0;
            acc        <= '0;
            sticky     <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_over_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.valid) begin
                        op_q    <= req.op;
                        len_q   <= req.len;
                        rs1_q   <= req.rs1;
                        rs2_q   <= req.rs2;
                        rd_q    <= req.rd;
                        k       <= '0;
                        acc     <= '0;
                        sticky  <= '0;
                        ready_q <= 1'b0;
                        if (req.len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!is_vdp) begin
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= rd_q + AW'(k);
                        wb_data_q  <= valu_res_i;
                        wb_over_q  <= valu_over_i;
                    end else begin
                        acc    <= acc_next;
                        sticky <= sticky_next;
                    end
                    if (last) begin
                        if (is_vdp) begin
                            // Reduced result is staged here so it is on the bus during REDUCE_WB.
                            state      <= REDUCE_WB;
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= rd_q;
                            wb_data_q  <= acc_next;
                            wb_over_q  <= sticky_next;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        k <= k + LEN_W'(1);
                    end
                end
                REDUCE_WB: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VSEQ_PERF_EN
    logic [15:0] ops_cnt;
    logic [15:0] words_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ops_cnt   <= '0;
            words_cnt <= '0;
        end else begin
            if (done_q)
                ops_cnt <= ops_cnt + 16'd1;
            if (state == ISSUE)
                words_cnt <= words_cnt + 16'd1;
        end
    end

    assign ops_cnt_o   = ops_cnt;
    assign words_cnt_o = words_cnt;
`endif

endmodule
